afg_reg_sequencer: RTL and testbench
====================================

Name: afg_reg_sequencer

Overview:
Controller for a bank of DEPTH 12-bit enable-gated sample registers in the arbitrary function generator. It shares the bank's single write bus between a host loader and a bulk-clear sweeper. It also sequences playback by stepping the read-select address on each sample tick. The bank registers are external; this block drives their per-register EN strobes, the shared Din bus, and the readout mux select.

Parameters:
DEPTH, 16, number of sample registers in the bank (2..2**AW)
AW, 4, address width
DW, 12, sample data width

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous reset, active-high
WrReq  input  1  host write request, level
WrAddr  input  AW  host write target register
WrData  input  DW  host write sample value
WrAck  output  1  one-cycle pulse: write issued to bank
ClrReq  input  1  request bulk clear of all registers (pulse or level)
Run  input  1  playback enable, level
Tick  input  1  sample-rate strobe, one cycle wide
LastAddr  input  AW  final playback address (inclusive)
RegEN  output  DEPTH  one-hot write enables to bank (all-zero when idle)
RegDin  output  DW  shared write data to bank
RdAddr  output  AW  readout mux select
SampleStrobe  output  1  pulse: RdAddr just changed to a new sample
Wrap  output  1  pulse: playback wrapped LastAddr -> 0
Busy  output  1  high while clear sweep runs

Behaviour:
- All outputs are registered. On Reset (sync, active-high): state IDLE; RegEN, RegDin, RdAddr, WrAck, SampleStrobe, Wrap, Busy = 0; clear counter = 0. Reset mid-sweep or mid-playback aborts immediately.
- States: IDLE, PLAY, CLEAR.
- IDLE -> CLEAR when ClrReq=1. Otherwise IDLE -> PLAY when Run=1; RdAddr is set to 0 on entry.
- PLAY -> CLEAR when ClrReq=1. Otherwise PLAY -> IDLE when Run=0; RdAddr holds its value in IDLE.
- CLEAR -> IDLE after the sweep completes, regardless of Run. Run must be re-sampled high to restart playback.
- Host write:
  - Accepted in IDLE or PLAY when WrReq=1, WrAck=0 and no ClrReq in the same cycle.
  - Next cycle: RegEN[WrAddr]=1, RegDin=WrData, WrAck=1, each for exactly one cycle. Latency is 1 cycle from acceptance to strobe.
  - Max rate: one write per 2 cycles, because a cycle with WrAck=1 does not accept.
  - The host drops WrReq or changes the address in the cycle after WrAck.
  - WrAddr >= DEPTH: WrAck is still pulsed, RegEN stays all-zero, and no register changes.
  - A WrReq in CLEAR is not acked. It stays pending and is served in the first IDLE cycle after the sweep.
  - ClrReq beats WrReq in the same cycle.
- Clear sweep:
  - Entered with counter=0 and Busy=1.
  - Each cycle drives RegEN = one-hot(counter) and RegDin = 0, then counter+1.
  - After the cycle with counter=DEPTH-1: Busy=0, RegEN=0, RdAddr=0, state IDLE. The sweep lasts exactly DEPTH cycles.
  - ClrReq during CLEAR is ignored; no restart.
- Playback:
  - In PLAY, a Tick in cycle n updates RdAddr in cycle n+1, with SampleStrobe=1 in n+1.
  - Effective end address E = min(LastAddr, DEPTH-1).
  - If RdAddr >= E: RdAddr <- 0 and Wrap=1 for one cycle. Otherwise RdAddr <- RdAddr+1. The >= compare covers LastAddr being lowered below RdAddr mid-play.
  - E=0: RdAddr stays 0, and every Tick pulses both SampleStrobe and Wrap.
  - Tick outside PLAY is ignored.
  - Host writes during PLAY are allowed and independent of stepping; the same cycle may carry both RegEN and SampleStrobe.
  - Tick in the same cycle as Run falling: Tick ignored; IDLE next cycle.

Test Plan:
- Reset: assert Reset 2 cycles mid-PLAY with RdAddr=5 -> next cycle all outputs 0, state IDLE.
- Host write: WrReq=1, WrAddr=3, WrData=0xA5C for 1 cycle in IDLE -> next cycle RegEN=0x0008, RegDin=0xA5C, WrAck=1. WrReq held high 4 cycles -> acks on alternate cycles only.
- Clear: ClrReq pulse in PLAY at RdAddr=7 -> Busy=1 for 16 cycles, RegEN walks 0x0001..0x8000 with RegDin=0, then RdAddr=0, IDLE. WrReq(addr 2) raised during the sweep -> acked the first cycle after Busy falls.
- Playback wrap: Run=1, LastAddr=3, Tick every 4 cycles -> RdAddr 0,1,2,3,0,1. Wrap pulses on each 3->0; SampleStrobe one cycle after each Tick.
- LastAddr change: at RdAddr=6 set LastAddr=4 -> next Tick gives RdAddr=0 with Wrap=1. LastAddr=0 -> RdAddr fixed at 0, Wrap on every Tick.
- Collision: ClrReq and WrReq in the same IDLE cycle -> CLEAR entered, no WrAck until the sweep ends. A write during PLAY coincident with Tick -> both RegEN and SampleStrobe asserted in the same cycle.

Source files
------------

// File: rtl/afg_reg_sequencer.sv
// ---------------------------------------------------------------------------
// afg_reg_sequencer
//
// Controller for a bank of DEPTH enable-gated sample registers in the
// arbitrary function generator. It shares the bank's single write bus between
// host writes and a bulk-clear sweeper. It also steps the readout mux select
// through the bank, one sample per Tick, while Run is high.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous reset, active-high
//   WrReq        in   host write request (level)
//   WrAddr       in   host write target register [AW]
//   WrData       in   host write sample value [DW]
//   WrAck        out  one-cycle pulse: host write issued to the bank
//   ClrReq       in   bulk clear request (pulse or level)
//   Run          in   playback enable (level)
//   Tick         in   sample-rate strobe, one cycle wide
//   LastAddr     in   final playback address, inclusive [AW]
//   RegEN        out  one-hot write enables to the bank [DEPTH]
//   RegDin       out  shared write data to the bank [DW]
//   RdAddr       out  readout mux select [AW]
//   SampleStrobe out  pulse: RdAddr just moved to a new sample
//   Wrap         out  pulse: playback wrapped back to address 0
//   Busy         out  high while the clear sweep runs
// ---------------------------------------------------------------------------
module afg_reg_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 12
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             WrReq,
  input  logic [AW-1:0]    WrAddr,
  input  logic [DW-1:0]    WrData,
  output logic             WrAck,
  input  logic             ClrReq,
  input  logic             Run,
  input  logic             Tick,
  input  logic [AW-1:0]    LastAddr,
  output logic [DEPTH-1:0] RegEN,
  output logic [DW-1:0]    RegDin,
  output logic [AW-1:0]    RdAddr,
  output logic             SampleStrobe,
  output logic             Wrap,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Highest valid register index, and DEPTH in one extra bit so that range
  // checks against it never degenerate when DEPTH == 2**AW.
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  state_t           state, state_next;
  logic [AW-1:0]    counter, counter_next;

  logic [DEPTH-1:0] reg_en_next;
  logic [DW-1:0]    reg_din_next;
  logic [AW-1:0]    rd_addr_next;
  logic             wr_ack_next;
  logic             strobe_next;
  logic             wrap_next;
  logic             busy_next;

  logic             accept;
  logic             step;
  logic             sweep_done;
  logic             addr_in_range;
  logic [AW-1:0]    end_addr;

  // A write is taken in IDLE/PLAY unless the previous one is still being
  // acked (which caps the rate at one per two cycles) or a clear wins.
  assign accept        = (state != CLEAR) && WrReq && !WrAck && !ClrReq;
  // Stepping only happens when PLAY persists; Run falling or ClrReq drops the Tick.
  assign step          = (state == PLAY) && Run && !ClrReq && Tick;
  assign sweep_done    = (state == CLEAR) && (counter == LAST_IDX);
  assign addr_in_range = ({1'b0, WrAddr} < DEPTH_W);
  // Effective end address: LastAddr clamped to the last real register.
  assign end_addr      = ({1'b0, LastAddr} > {1'b0, LAST_IDX}) ? LAST_IDX : LastAddr;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      counter      <= '0;
      RegEN        <= '0;
      RegDin       <= '0;
      RdAddr       <= '0;
      WrAck        <= 1'b0;
      SampleStrobe <= 1'b0;
      Wrap         <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      state        <= state_next;
      counter      <= counter_next;
      RegEN        <= reg_en_next;
      RegDin       <= reg_din_next;
      RdAddr       <= rd_addr_next;
      WrAck        <= wr_ack_next;
      SampleStrobe <= strobe_next;
      Wrap         <= wrap_next;
      Busy         <= busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (ClrReq)   state_next = CLEAR;
        else if (Run) state_next = PLAY;
      end
      PLAY: begin
        if (ClrReq)    state_next = CLEAR;
        else if (!Run) state_next = IDLE;
      end
      CLEAR: begin
        // Always back to IDLE; Run has to be seen again to resume playback.
        if (sweep_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values for the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    counter_next = counter;
    reg_en_next  = '0;
    reg_din_next = '0;
    rd_addr_next = RdAddr;
    wr_ack_next  = 1'b0;
    strobe_next  = 1'b0;
    wrap_next    = 1'b0;
    busy_next    = 1'b0;

    // Clear sweep: the registered outputs of a CLEAR cycle already show that
    // cycle's counter, so the sweep visibly starts at index 0 on entry.
    if (state_next == CLEAR) begin
      counter_next = (state == CLEAR) ? counter + AW'(1) : '0;
      busy_next    = 1'b1;
      reg_en_next  = DEPTH'(1) << counter_next;
    end

    if (sweep_done) begin
      counter_next = '0;
      rd_addr_next = '0;
    end

    // Never overlaps the sweep: acceptance excludes CLEAR and ClrReq.
    if (accept) begin
      wr_ack_next  = 1'b1;
      reg_din_next = WrData;
      if (addr_in_range) reg_en_next = DEPTH'(1) << WrAddr;
    end

    if ((state == IDLE) && (state_next == PLAY)) rd_addr_next = '0;

    // The >= (not ==) wraps immediately if LastAddr was lowered under RdAddr.
    if (step) begin
      strobe_next = 1'b1;
      if (RdAddr >= end_addr) begin
        rd_addr_next = '0;
        wrap_next    = 1'b1;
      end else begin
        rd_addr_next = RdAddr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_afg_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_afg_reg_sequencer
//
// Self-checking bench for afg_reg_sequencer (DEPTH=16, AW=4, DW=12).
// A table of directed vectors covers host writes, playback stepping and
// wrap; hand-written sequences cover the clear sweep, clear/write collision
// and reset during playback. Inputs change 1 ns after the rising edge and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_afg_reg_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 12;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             WrReq;
  logic [AW-1:0]    WrAddr;
  logic [DW-1:0]    WrData;
  logic             WrAck;
  logic             ClrReq;
  logic             Run;
  logic             Tick;
  logic [AW-1:0]    LastAddr;
  logic [DEPTH-1:0] RegEN;
  logic [DW-1:0]    RegDin;
  logic [AW-1:0]    RdAddr;
  logic             SampleStrobe;
  logic             Wrap;
  logic             Busy;

  int checks   = 0;
  int failures = 0;

  afg_reg_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .WrReq        (WrReq),
    .WrAddr       (WrAddr),
    .WrData       (WrData),
    .WrAck        (WrAck),
    .ClrReq       (ClrReq),
    .Run          (Run),
    .Tick         (Tick),
    .LastAddr     (LastAddr),
    .RegEN        (RegEN),
    .RegDin       (RegDin),
    .RdAddr       (RdAddr),
    .SampleStrobe (SampleStrobe),
    .Wrap         (Wrap),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string            name;
    logic             wr_req;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             clr;
    logic             run;
    logic             tick;
    logic [AW-1:0]    last;
    logic [DEPTH-1:0] en;
    logic [DW-1:0]    din;
    logic [AW-1:0]    rd;
    logic             ack;
    logic             strobe;
    logic             wrap;
    logic             busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string name,
    input logic wr_req, input logic [AW-1:0] wr_addr, input logic [DW-1:0] wr_data,
    input logic clr, input logic run, input logic tick, input logic [AW-1:0] last,
    input logic [DEPTH-1:0] en, input logic [DW-1:0] din, input logic [AW-1:0] rd,
    input logic ack, input logic strobe, input logic wrap, input logic busy);
    vec_t v;
    v.name = name;  v.wr_req = wr_req; v.wr_addr = wr_addr; v.wr_data = wr_data;
    v.clr  = clr;   v.run    = run;    v.tick    = tick;    v.last    = last;
    v.en   = en;    v.din    = din;    v.rd      = rd;      v.ack     = ack;
    v.strobe = strobe; v.wrap = wrap;  v.busy    = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_outs(input string name,
                            input logic [DEPTH-1:0] en, input logic [DW-1:0] din,
                            input logic [AW-1:0] rd, input logic ack,
                            input logic strobe, input logic wrap, input logic busy);
    check({name, ".RegEN"},        32'(RegEN),        32'(en));
    check({name, ".RegDin"},       32'(RegDin),       32'(din));
    check({name, ".RdAddr"},       32'(RdAddr),       32'(rd));
    check({name, ".WrAck"},        32'(WrAck),        32'(ack));
    check({name, ".SampleStrobe"}, 32'(SampleStrobe), 32'(strobe));
    check({name, ".Wrap"},         32'(Wrap),         32'(wrap));
    check({name, ".Busy"},         32'(Busy),         32'(busy));
  endtask

  task automatic drive(input logic wr_req, input logic [AW-1:0] wr_addr,
                       input logic [DW-1:0] wr_data, input logic clr,
                       input logic run, input logic tick, input logic [AW-1:0] last);
    WrReq = wr_req; WrAddr = wr_addr; WrData = wr_data;
    ClrReq = clr;   Run = run;        Tick = tick;     LastAddr = last;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int exp_rd[5];
    string nm;

    Reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);

    // ---------------- reset state ----------------
    step();
    step();
    check_outs("reset", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

    // ---------------- vector table ----------------
    //                   name           wr  addr   data    clr  run  tick last | en         din     rd  ack stb wrp bsy
    vecs.push_back(mk("wr_idle",     1, 4'd3, 12'hA5C, 0, 0, 0, 4'd0,  16'h0008, 12'hA5C, 4'd0, 1, 0, 0, 0));
    vecs.push_back(mk("wr_drop",     0, 4'd3, 12'hA5C, 0, 0, 0, 4'd0,  16'h0000, 12'h000, 4'd0, 0, 0, 0, 0));
    vecs.push_back(mk("wr_hold1",    1, 4'd5, 12'h123, 0, 0, 0, 4'd0,  16'h0020, 12'h123, 4'd0, 1, 0, 0, 0));
    vecs.push_back(mk("wr_hold2",    1, 4'd5, 12'h123, 0, 0, 0, 4'd0,  16'h0000, 12'h000, 4'd0, 0, 0, 0, 0));
    vecs.push_back(mk("wr_hold3",    1, 4'd5, 12'h123, 0, 0, 0, 4'd0,  16'h0020, 12'h123, 4'd0, 1, 0, 0, 0));
    vecs.push_back(mk("wr_hold4",    1, 4'd5, 12'h123, 0, 0, 0, 4'd0,  16'h0000, 12'h000, 4'd0, 0, 0, 0, 0));
    vecs.push_back(mk("wr_off",      0, 4'd0, 12'h000, 0, 0, 0, 4'd0,  16'h0000, 12'h000, 4'd0, 0, 0, 0, 0));
    vecs.push_back(mk("play_enter",  0, 4'd0, 12'h000, 0, 1, 0, 4'd3,  16'h0000, 12'h000, 4'd0, 0, 0, 0, 0));

    // LastAddr=3, one Tick every 4 cycles: 1,2,3,0 (wrap),1
    exp_rd = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      nm = $sformatf("tick3_%0d", i);
      vecs.push_back(mk(nm, 0, 4'd0, 12'h000, 0, 1, 1, 4'd3,
                        16'h0000, 12'h000, 4'(exp_rd[i]), 0, 1, (exp_rd[i] == 0), 0));
      for (int g = 0; g < 3; g++)
        vecs.push_back(mk({nm, $sformatf("_gap%0d", g)}, 0, 4'd0, 12'h000, 0, 1, 0, 4'd3,
                          16'h0000, 12'h000, 4'(exp_rd[i]), 0, 0, 0, 0));
    end

    // Back-to-back Ticks up to RdAddr=6 with LastAddr=15
    for (int a = 2; a <= 6; a++)
      vecs.push_back(mk($sformatf("tick15_%0d", a), 0, 4'd0, 12'h000, 0, 1, 1, 4'd15,
                        16'h0000, 12'h000, 4'(a), 0, 1, 0, 0));
    vecs.push_back(mk("last_lower",  0, 4'd0, 12'h000, 0, 1, 1, 4'd4,  16'h0000, 12'h000, 4'd0, 0, 1, 1, 0));
    vecs.push_back(mk("last0_a",     0, 4'd0, 12'h000, 0, 1, 1, 4'd0,  16'h0000, 12'h000, 4'd0, 0, 1, 1, 0));
    vecs.push_back(mk("last0_gap",   0, 4'd0, 12'h000, 0, 1, 0, 4'd0,  16'h0000, 12'h000, 4'd0, 0, 0, 0, 0));
    vecs.push_back(mk("last0_b",     0, 4'd0, 12'h000, 0, 1, 1, 4'd0,  16'h0000, 12'h000, 4'd0, 0, 1, 1, 0));
    vecs.push_back(mk("wr_tick",     1, 4'd9, 12'h7E1, 0, 1, 1, 4'd15, 16'h0200, 12'h7E1, 4'd1, 1, 1, 0, 0));
    vecs.push_back(mk("wr_tick_aft", 0, 4'd0, 12'h000, 0, 1, 0, 4'd15, 16'h0000, 12'h000, 4'd1, 0, 0, 0, 0));
    vecs.push_back(mk("run_fall",    0, 4'd0, 12'h000, 0, 0, 1, 4'd15, 16'h0000, 12'h000, 4'd1, 0, 0, 0, 0));
    vecs.push_back(mk("idle_tick",   0, 4'd0, 12'h000, 0, 0, 1, 4'd15, 16'h0000, 12'h000, 4'd1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].wr_req, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].clr,
            vecs[i].run, vecs[i].tick, vecs[i].last);
      step();
      check_outs(vecs[i].name, vecs[i].en, vecs[i].din, vecs[i].rd, vecs[i].ack,
                 vecs[i].strobe, vecs[i].wrap, vecs[i].busy);
    end

    // ---------------- clear sweep from PLAY at RdAddr=7 ----------------
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'd15);
    step();                                   // IDLE -> PLAY, RdAddr=0
    Tick = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("clr_pre.RdAddr", 32'(RdAddr), 32'd7);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 4'd15);
    step();                                   // CLEAR entered
    drive(1'b1, 4'd2, 12'h3C3, 1'b0, 1'b1, 1'b0, 4'd15);
    for (int i = 0; i < DEPTH; i++) begin
      check_outs($sformatf("sweep_%0d", i), 16'(1) << i, 12'h000, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      ClrReq = (i == 4);                      // ignored mid-sweep
      step();
    end
    check_outs("sweep_exit", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    ClrReq = 1'b0;
    step();
    check_outs("sweep_wr", 16'h0004, 12'h3C3, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 4'd15);
    step();
    check_outs("replay_tick", '0, '0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // ---------------- ClrReq and WrReq in the same IDLE cycle ----------------
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 4'd15);
    step();                                   // PLAY -> IDLE
    drive(1'b1, 4'd6, 12'h0F0, 1'b1, 1'b0, 1'b0, 4'd15);
    step();
    check_outs("coll_enter", 16'h0001, 12'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    ClrReq = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      step();
      check($sformatf("coll_sweep_%0d.WrAck", i), 32'(WrAck), 32'd0);
      check($sformatf("coll_sweep_%0d.RegEN", i), 32'(RegEN), 32'(16'(1) << i));
    end
    step();
    check_outs("coll_exit", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("coll_wr", 16'h0040, 12'h0F0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    WrReq = 1'b0;

    // ---------------- reset mid-PLAY at RdAddr=5 ----------------
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'd15);
    step();                                   // IDLE -> PLAY
    Tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rst_pre.RdAddr", 32'(RdAddr), 32'd5);
    Reset = 1'b1;
    drive(1'b1, 4'd1, 12'hFFF, 1'b0, 1'b1, 1'b1, 4'd15);
    step();
    check_outs("rst_mid_1", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("rst_mid_2", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4'd15);
    step();                                   // Tick in IDLE must not step
    check_outs("rst_after", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
